// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache miss-side memory interface: responder
// FSM states, line geometry and the request type encoding.
package cache_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RLAT   = 3'd1,
      ST_RBURST = 3'd2,
      ST_WBURST = 3'd3,
      ST_WLAT   = 3'd4,
      ST_WDONE  = 3'd5
   } state_t;

   // Default line geometry: 8 words of 32 bits.
   localparam int WORDS_PER_LINE_DEF = 8;
   localparam int LINE_BYTES         = WORDS_PER_LINE_DEF * 4;
   localparam int OFFSET_BITS        = $clog2(LINE_BYTES);

   // Request type carried on mem_we.
   typedef enum logic {
      REQ_FILL = 1'b0,
      REQ_WB   = 1'b1
   } req_type_e;

   // Byte-offset width of a line for an arbitrary line size.
   function automatic int offset_bits(input int words_per_line);
      return $clog2(words_per_line * 4);
   endfunction

endpackage

// File: rtl/cache_mem_responder_mem_array.sv
// Single-port word RAM with synchronous write and synchronous read.
// Contents are never reset; the power-up pattern is each word holding its
// own byte address. Only the read-data register is reset.
module mem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   typedef logic [DEPTH-1:0][31:0] mem_t;

   function automatic mem_t init_pattern();
      mem_t m;
      for (int i = 0; i < int'(DEPTH); i++) begin
         m[i] = 32'(i * 4);
      end
      return m;
   endfunction

   mem_t        mem_q = init_pattern();
   logic [31:0] rdata_q;

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Registered read port.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Miss-side main-memory responder. Accepts one line request at a time,
// waits a fixed latency, then streams (fill) or absorbs (write-back) the
// line as word beats. Keeps wrapping read/write request counters.
//
// Handshakes: a request transfers on a rising edge where mem_req and
// req_ready are both high; a write beat transfers on an edge where wvalid
// and wready are both high; read beats are valid whenever rvalid is high
// and cannot be stalled.
module cache_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int unsigned WORDS_PER_LINE = 8,
   parameter int unsigned MEM_WORDS      = 1024,
   parameter int unsigned LATENCY        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   output logic        req_ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        rlast,
   input  logic        wvalid,
   input  logic [31:0] wdata,
   output logic        wready,
   output logic        wdone,
   output logic [31:0] total_reads,
   output logic [31:0] total_writes,
   output state_t      dbg_state
);

   localparam int AW    = $clog2(MEM_WORDS);
   localparam int KW    = $clog2(WORDS_PER_LINE);
   localparam int LINEW = AW - KW;
   localparam int OFFB  = offset_bits(int'(WORDS_PER_LINE));
   localparam int LW    = $clog2(LATENCY + 2);

   state_t            state_q;
   logic [LINEW-1:0]  line_q;
   logic [KW-1:0]     k_q;
   logic [KW-1:0]     k_d;
   logic [LW-1:0]     lat_q;
   logic              req_ready_q;
   logic              rvalid_q;
   logic              rlast_q;
   logic              wready_q;
   logic              wdone_q;
   logic [31:0]       total_reads_q;
   logic [31:0]       total_writes_q;
   logic [31:0]       total_reads_d;
   logic [31:0]       total_writes_d;

   logic [LINEW-1:0]  req_line;
   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [31:0]       ram_rdata;
   logic              unused_addr;

   // Upper address bits wrap away; low bits select a byte within the line.
   assign req_line    = mem_addr[OFFB+LINEW-1:OFFB];
   assign unused_addr = ^{mem_addr[31:OFFB+LINEW], mem_addr[OFFB-1:0]};

   assign k_d            = k_q + KW'(1);
   assign total_reads_d  = total_reads_q + 32'd1;
   assign total_writes_d = total_writes_q + 32'd1;

   // RAM port steering: reads run one word ahead of the beat on rdata so
   // consecutive beats need no bubble.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = {line_q, k_q};
      case (state_q)
         ST_IDLE:   ram_addr = {req_line, {KW{1'b0}}};
         ST_RLAT:   ram_addr = {line_q, {KW{1'b0}}};
         ST_RBURST: ram_addr = {line_q, k_d};
         ST_WBURST: ram_we   = wvalid;
         default:   ram_addr = {line_q, k_q};
      endcase
   end

   mem_array #(
      .DEPTH (MEM_WORDS),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .rst_ni  (rst),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wdata),
      .rdata_o (ram_rdata)
   );

   // Responder FSM with registered handshake outputs and request counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         line_q         <= '0;
         k_q            <= '0;
         lat_q          <= '0;
         req_ready_q    <= 1'b1;
         rvalid_q       <= 1'b0;
         rlast_q        <= 1'b0;
         wready_q       <= 1'b0;
         wdone_q        <= 1'b0;
         total_reads_q  <= '0;
         total_writes_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_req) begin
                  line_q      <= req_line;
                  k_q         <= '0;
                  lat_q       <= LW'(LATENCY);
                  req_ready_q <= 1'b0;
                  if (mem_we == REQ_WB) begin
                     total_writes_q <= total_writes_d;
                     wready_q       <= 1'b1;
                     state_q        <= ST_WBURST;
                  end else begin
                     total_reads_q <= total_reads_d;
                     if (LATENCY == 0) begin
                        rvalid_q <= 1'b1;
                        state_q  <= ST_RBURST;
                     end else begin
                        state_q  <= ST_RLAT;
                     end
                  end
               end
            end
            ST_RLAT: begin
               if (lat_q == LW'(1)) begin
                  rvalid_q <= 1'b1;
                  state_q  <= ST_RBURST;
               end else begin
                  lat_q <= lat_q - LW'(1);
               end
            end
            ST_RBURST: begin
               k_q <= k_d;
               if (k_q == KW'(WORDS_PER_LINE - 2)) begin
                  rlast_q <= 1'b1;
               end
               if (k_q == KW'(WORDS_PER_LINE - 1)) begin
                  rvalid_q    <= 1'b0;
                  rlast_q     <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_WBURST: begin
               if (wvalid) begin
                  k_q <= k_d;
                  if (k_q == KW'(WORDS_PER_LINE - 1)) begin
                     wready_q <= 1'b0;
                     if (LATENCY == 0) begin
                        wdone_q <= 1'b1;
                        state_q <= ST_WDONE;
                     end else begin
                        state_q <= ST_WLAT;
                     end
                  end
               end
            end
            ST_WLAT: begin
               if (lat_q == LW'(1)) begin
                  wdone_q <= 1'b1;
                  state_q <= ST_WDONE;
               end else begin
                  lat_q <= lat_q - LW'(1);
               end
            end
            ST_WDONE: begin
               wdone_q     <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign rvalid       = rvalid_q;
   assign rlast        = rlast_q;
   assign rdata        = rvalid_q ? ram_rdata : 32'd0;
   assign wready       = wready_q;
   assign wdone        = wdone_q;
   assign total_reads  = total_reads_q;
   assign total_writes = total_writes_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: scenario tasks drive requests, expected
// read beats come from a reference memory model into a queue and are
// compared as the DUT produces them.
module tb_cache_mem_responder;
   import cache_mem_pkg::*;

   localparam int W  = 8;
   localparam int L  = 4;
   localparam int MW = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        req_ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        rlast;
   logic        wvalid;
   logic [31:0] wdata;
   logic        wready;
   logic        wdone;
   logic [31:0] total_reads;
   logic [31:0] total_writes;
   state_t      dbg_state;

   logic [31:0] model_q [MW];
   logic [31:0] exp_q [$];
   logic [31:0] exp_reads;
   logic [31:0] exp_writes;
   int          n_vec;
   int          n_err;

   cache_mem_responder #(
      .WORDS_PER_LINE (W),
      .MEM_WORDS      (MW),
      .LATENCY        (L)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .req_ready    (req_ready),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .rlast        (rlast),
      .wvalid       (wvalid),
      .wdata        (wdata),
      .wready       (wready),
      .wdone        (wdone),
      .total_reads  (total_reads),
      .total_writes (total_writes),
      .dbg_state    (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int word_idx(input logic [31:0] addr, input int k);
      return int'((((addr >> 5) * W) + k) % MW);
   endfunction

   // Present a request at a negedge and let the next rising edge take it.
   task automatic accept(input logic [31:0] addr, input logic we);
      mem_req  = 1'b1;
      mem_we   = we;
      mem_addr = addr;
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL accept_ready addr=%h: got %b want 1", addr, req_ready);
      end
      if (we) begin
         exp_writes++;
      end else begin
         exp_reads++;
         for (int k = 0; k < W; k++) exp_q.push_back(model_q[word_idx(addr, k)]);
      end
      @(posedge clk);
      #1;
      mem_req = 1'b0;
      mem_we  = 1'b0;
   endtask

   // Cycle-by-cycle read burst check; optionally holds a new request while
   // busy, or pulls reset at cycle abort_c.
   task automatic watch_read(input bit hold, input logic [31:0] next_addr,
                             input int abort_c, input string tag);
      logic [31:0] e;
      logic        exp_rv;
      for (int c = 0; c <= L + W; c++) begin
         @(negedge clk);
         if (hold && c == 0) begin
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            mem_addr = next_addr;
         end
         exp_rv = (c >= L && c < L + W);
         n_vec++;
         if (rvalid !== exp_rv) begin
            n_err++;
            $display("FAIL %s rvalid c=%0d: got %b want %b", tag, c, rvalid, exp_rv);
         end
         n_vec++;
         if (rlast !== 1'(c == L + W - 1)) begin
            n_err++;
            $display("FAIL %s rlast c=%0d: got %b want %b", tag, c, rlast, (c == L + W - 1));
         end
         n_vec++;
         if (req_ready !== 1'(c == L + W)) begin
            n_err++;
            $display("FAIL %s req_ready c=%0d: got %b want %b", tag, c, req_ready, (c == L + W));
         end
         n_vec++;
         if (total_reads !== exp_reads) begin
            n_err++;
            $display("FAIL %s total_reads c=%0d: got %0d want %0d", tag, c, total_reads, exp_reads);
         end
         if (rvalid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra_beat c=%0d: got %h want none", tag, c, rdata);
            end else begin
               e = exp_q.pop_front();
               if (rdata !== e) begin
                  n_err++;
                  $display("FAIL %s rdata c=%0d: got %h want %h", tag, c, rdata, e);
               end
            end
         end
         if (c == abort_c) begin
            rst = 1'b0;
            #1;
            n_vec++;
            if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== 32'd0 || req_ready !== 1'b1) begin
               n_err++;
               $display("FAIL %s async_reset: rvalid=%b rlast=%b rdata=%h req_ready=%b want 0 0 0 1",
                        tag, rvalid, rlast, rdata, req_ready);
            end
            exp_q.delete();
            exp_reads  = 32'd0;
            exp_writes = 32'd0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            n_vec++;
            if (total_reads !== exp_reads || total_writes !== exp_writes || dbg_state !== ST_IDLE) begin
               n_err++;
               $display("FAIL %s post_reset: reads=%0d writes=%0d state=%0d want 0 0 %0d",
                        tag, total_reads, total_writes, dbg_state, ST_IDLE);
            end
            return;
         end
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s leftover: got %0d beats missing want 0", tag, exp_q.size());
      end
   endtask

   // Write-back beats with an optional two-cycle wvalid gap after one beat.
   task automatic watch_write(input logic [31:0] addr, input int gap_after, input string tag);
      @(negedge clk);
      n_vec++;
      if (wready !== 1'b1 || total_writes !== exp_writes) begin
         n_err++;
         $display("FAIL %s wr_start: wready=%b writes=%0d want 1 %0d", tag, wready, total_writes, exp_writes);
      end
      for (int k = 0; k < W; k++) begin
         wvalid = 1'b1;
         wdata  = 32'hA5A5A5A0 + 32'(k);
         model_q[word_idx(addr, k)] = wdata;
         @(negedge clk);
         wvalid = 1'b0;
         if (k == gap_after) begin
            repeat (2) begin
               n_vec++;
               if (wready !== 1'b1 || wdone !== 1'b0) begin
                  n_err++;
                  $display("FAIL %s gap: wready=%b wdone=%b want 1 0", tag, wready, wdone);
               end
               @(negedge clk);
            end
         end
      end
      for (int j = 0; j <= L; j++) begin
         n_vec++;
         if (wdone !== 1'(j == L) || wready !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s wdone j=%0d: wdone=%b wready=%b req_ready=%b want %b 0 0",
                     tag, j, wdone, wready, req_ready, (j == L));
         end
         if (j < L) @(negedge clk);
      end
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || wdone !== 1'b0 || total_writes !== exp_writes) begin
         n_err++;
         $display("FAIL %s wr_end: req_ready=%b wdone=%b writes=%0d want 1 0 %0d",
                  tag, req_ready, wdone, total_writes, exp_writes);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (rvalid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_hold: rvalid=%b req_ready=%b want 0 1", rvalid, req_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || rvalid !== 1'b0 || rlast !== 1'b0 || wready !== 1'b0 ||
          wdone !== 1'b0 || rdata !== 32'd0 || total_reads !== 32'd0 || total_writes !== 32'd0) begin
         n_err++;
         $display("FAIL reset_values: rr=%b rv=%b rl=%b wr=%b wd=%b rd=%h tr=%0d tw=%0d want 1 0 0 0 0 0 0 0",
                  req_ready, rvalid, rlast, wready, wdone, rdata, total_reads, total_writes);
      end
   endtask

   task automatic test_read();
      accept(32'h20, 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_20");
   endtask

   task automatic test_write();
      accept(32'h40, 1'b1);
      watch_write(32'h40, 3, "write_40");
   endtask

   task automatic test_back_to_back();
      accept(32'h40, 1'b0);
      watch_read(1'b1, 32'h80, -1, "read_40_busy");
      accept(32'h80, 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_80");
   endtask

   task automatic test_unaligned();
      accept(32'h5C, 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_5c");
      // Upper bits beyond the backing store wrap onto the same line.
      accept(32'h0001_0020 + 32'(MW * 4), 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_wrap");
   endtask

   task automatic test_wvalid_ignored();
      mem_addr = 32'h0;
      wvalid   = 1'b1;
      wdata    = 32'hDEADBEEF;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if (wready !== 1'b0 || wdone !== 1'b0 || total_writes !== exp_writes) begin
            n_err++;
            $display("FAIL idle_wvalid: wready=%b wdone=%b writes=%0d want 0 0 %0d",
                     wready, wdone, total_writes, exp_writes);
         end
      end
      wvalid = 1'b0;
      accept(32'h0, 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_00");
   endtask

   task automatic test_mid_reset();
      accept(32'h0, 1'b0);
      watch_read(1'b0, 32'h0, L + 3, "abort");
      accept(32'h40, 1'b0);
      watch_read(1'b0, 32'h0, -1, "read_40_after_reset");
   endtask

   initial begin
      for (int i = 0; i < MW; i++) model_q[i] = 32'(i * 4);
      n_vec      = 0;
      n_err      = 0;
      exp_reads  = 32'd0;
      exp_writes = 32'd0;
      rst        = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'h0;
      wvalid     = 1'b0;
      wdata      = 32'h0;

      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_unaligned();
      test_wvalid_ignored();
      test_mid_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
